// File: rtl/multicycle_core_pkg.sv
// Shared opcode/state types and instruction field positions for multicycle_core.
// Instruction word: [31:29] op, [28:24] ra, [23:19] rb, [18:14] rd, [13:0] addr.
package multicycle_core_pkg;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 29;
    localparam int RA_MSB   = 28;
    localparam int RA_LSB   = 24;
    localparam int RB_MSB   = 23;
    localparam int RB_LSB   = 19;
    localparam int RD_MSB   = 18;
    localparam int RD_LSB   = 14;
    localparam int ADDR_MSB = 13;

    typedef enum logic [2:0] {
        OP_LD  = 3'd0,
        OP_ST  = 3'd1,
        OP_BEQ = 3'd2,
        OP_BNE = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5,
        OP_AND = 3'd6,
        OP_OR  = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

endpackage

// File: rtl/multicycle_core_regfile.sv
// Register file: two async read ports, one sync write port, async reset.
// MULTICYCLE_CORE_ZERO_REG_EN makes R0 a hardwired zero.
module core_regfile
    import multicycle_core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra_addr,
    input  logic [4:0]      rb_addr,
    output logic [XLEN-1:0] ra_data,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs [NREGS];

    // Fields beyond NREGS (and R0 when hardwired) are not backed by storage
    function automatic logic reg_ok(logic [4:0] a);
`ifdef MULTICYCLE_CORE_ZERO_REG_EN
        return (int'(a) < NREGS) && (a != 5'd0);
`else
        return int'(a) < NREGS;
`endif
    endfunction

    assign ra_data = reg_ok(ra_addr) ? regs[ra_addr] : '0;
    assign rb_data = reg_ok(rb_addr) ? regs[rb_addr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && reg_ok(wr_addr)) begin
            regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB, req/ack memories, run gate, retire.
// Optional hardwired R0 via MULTICYCLE_CORE_ZERO_REG_EN (see core_regfile).
module multicycle_core
    import multicycle_core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int PC_W    = 16,
    parameter int DADDR_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic               dmem_ack,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic               retire
);

    state_t          state, state_nx;
    logic [31:0]     ir;
    logic [XLEN-1:0] opa, opb, res, alu, rf_a, rf_b;
    logic            rf_we, taken, is_br, is_mem;
    opcode_t         op;

    assign op        = opcode_t'(ir[OP_MSB:OP_LSB]);
    assign imem_addr = pc;
    assign is_br     = (op == OP_BEQ) || (op == OP_BNE);
    assign is_mem    = (op == OP_LD) || (op == OP_ST);
    assign taken     = (op == OP_BEQ) ? (opa == opb) : (opa != opb);

    core_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (ir[RA_MSB:RA_LSB]),
        .rb_addr (ir[RB_MSB:RB_LSB]),
        .ra_data (rf_a),
        .rb_data (rf_b),
        .we      (rf_we),
        .wr_addr (ir[RD_MSB:RD_LSB]),
        .wr_data (res)
    );

    always_comb begin
        alu = '0;
        unique case (op)
            OP_ADD:  alu = opa + opb;
            OP_SUB:  alu = opa - opb;
            OP_AND:  alu = opa & opb;
            OP_OR:   alu = opa | opb;
            default: alu = '0;
        endcase
    end

    // Requests are decoded from state so an async reset drops them at once
    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        retire   = 1'b0;
        rf_we    = 1'b0;
        unique case (state)
            FETCH: begin
                imem_req = run;
                if (run && imem_ack) state_nx = DECODE;
            end
            DECODE: state_nx = EXEC;
            EXEC: begin
                if (is_mem) begin
                    state_nx = MEM;
                end else if (is_br) begin
                    retire   = 1'b1;
                    state_nx = FETCH;
                end else begin
                    state_nx = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    retire   = (op == OP_ST);
                    state_nx = (op == OP_ST) ? FETCH : WB;
                end
            end
            WB: begin
                rf_we    = 1'b1;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= '0;
            ir         <= '0;
            opa        <= '0;
            opb        <= '0;
            res        <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir <= imem_rdata;
                        pc <= pc + PC_W'(1);
                    end
                end
                DECODE: begin
                    opa <= rf_a;
                    opb <= rf_b;
                end
                EXEC: begin
                    res <= alu;
                    if (is_br && taken) pc <= PC_W'(ir[ADDR_MSB:0]);
                    if (is_mem) begin
                        dmem_addr  <= DADDR_W'(ir[ADDR_MSB:0]);
                        dmem_we    <= (op == OP_ST);
                        dmem_wdata <= opa;
                    end
                end
                MEM: begin
                    if (dmem_ack) res <= dmem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule
